// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: fetch FSM encoding,
// program counter load selects and the reset/vector/NOP defaults.
package instruction_fetch_pkg;

  localparam int          DATA_WIDTH_DEFAULT        = 32;
  localparam int          INSTRUCTION_WIDTH_DEFAULT = 16;
  localparam logic [31:0] BOOT_ADDRESS_DEFAULT      = 32'h0000_0000;
  localparam logic [31:0] INTERRUPT_VECTOR_DEFAULT  = 32'h0000_0100;
  localparam logic [15:0] NOP_INSTRUCTION           = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_KEEP   = 2'd0,
    PC_INC    = 2'd1,
    PC_TARGET = 2'd2,
    PC_VECTOR = 2'd3
  } pc_sel_e;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/ready bus between the fetch stage (master)
// and instruction memory (slave).
interface instruction_fetch_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int INSTRUCTION_WIDTH = 16
) ();

  logic                         mem_request;
  logic [DATA_WIDTH-1:0]        mem_address;
  logic                         mem_ready;
  logic [INSTRUCTION_WIDTH-1:0] mem_data;

  modport master (output mem_request, output mem_address,
                  input  mem_ready,   input  mem_data);

  modport slave  (input  mem_request, input  mem_address,
                  output mem_ready,   output mem_data);

endinterface

// File: rtl/instruction_fetch_program_counter.sv
// Program counter register: keep, increment (wrapping), load a branch target
// or load the interrupt vector; resets to the boot address.
module instruction_fetch_program_counter
  import instruction_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH       = DATA_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDRESS     = BOOT_ADDRESS_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] INTERRUPT_VECTOR = INTERRUPT_VECTOR_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  pc_sel_e               sel,
  input  logic [DATA_WIDTH-1:0] target,
  output logic [DATA_WIDTH-1:0] pc
);

  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] pc_d;

  // next pc selection
  always_comb begin
    pc_d = pc_q;
    case (sel)
      PC_KEEP:   pc_d = pc_q;
      PC_INC:    pc_d = pc_q + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      PC_TARGET: pc_d = target;
      PC_VECTOR: pc_d = INTERRUPT_VECTOR;
      default:   pc_d = pc_q;
    endcase
  end

  // pc register
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= BOOT_ADDRESS;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: fetches one instruction at a time over the memory handshake,
// holds it for control, applies branches and redirects to the interrupt vector.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH        = DATA_WIDTH_DEFAULT,
  parameter int                    INSTRUCTION_WIDTH = INSTRUCTION_WIDTH_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDRESS      = BOOT_ADDRESS_DEFAULT,
  parameter logic [DATA_WIDTH-1:0] INTERRUPT_VECTOR  = INTERRUPT_VECTOR_DEFAULT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         should_branch,
  input  logic [DATA_WIDTH-1:0]        branch_target,
  input  logic                         interruption,
  input  logic                         is_os,
  instruction_fetch_if.master          mem,
  output logic [INSTRUCTION_WIDTH-1:0] Instruction,
  output logic                         instruction_valid,
  output logic [DATA_WIDTH-1:0]        pc,
  output logic [DATA_WIDTH-1:0]        return_address,
  output logic                         interrupt_taken
);

  fetch_state_e                 state_q,   state_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q,   instr_d;
  logic                         valid_q,   valid_d;
  logic [DATA_WIDTH-1:0]        ret_q,     ret_d;
  logic                         pending_q, pending_d;
  logic                         itaken_q,  itaken_d;
  logic [DATA_WIDTH-1:0]        addr_q,    addr_d;
  logic                         req_q,     req_d;

  pc_sel_e               pc_sel_s;
  logic [DATA_WIDTH-1:0] pc_s;
  logic [DATA_WIDTH-1:0] seq_next_s;
  logic                  take_s;
  logic                  can_take_s;

  instruction_fetch_program_counter #(
    .DATA_WIDTH       (DATA_WIDTH),
    .BOOT_ADDRESS     (BOOT_ADDRESS),
    .INTERRUPT_VECTOR (INTERRUPT_VECTOR)
  ) u_program_counter (
    .clock  (clock),
    .reset  (reset),
    .sel    (pc_sel_s),
    .target (branch_target),
    .pc     (pc_s)
  );

  assign seq_next_s = should_branch ? branch_target
                                    : pc_s + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  assign can_take_s = pending_q && !is_os;

  // fetch FSM next-state, interrupt redirect and output register updates
  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    ret_d    = ret_q;
    itaken_d = 1'b0;
    addr_d   = addr_q;
    pc_sel_s = PC_KEEP;
    take_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        addr_d  = pc_s;
      end
      ST_FETCH: begin
        if (can_take_s) begin
          // the in-flight word is abandoned; a pending beat must still drain
          take_s   = 1'b1;
          ret_d    = pc_s;
          pc_sel_s = PC_VECTOR;
          itaken_d = 1'b1;
          if (mem.mem_ready) begin
            state_d = ST_FETCH;
            addr_d  = INTERRUPT_VECTOR;
          end else begin
            state_d = ST_DRAIN;
          end
        end else if (mem.mem_ready) begin
          instr_d = mem.mem_data;
          valid_d = 1'b1;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (mem.mem_ready) begin
          state_d = ST_FETCH;
          addr_d  = pc_s;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (enable) begin
          valid_d = 1'b0;
          state_d = ST_FETCH;
          if (can_take_s) begin
            take_s   = 1'b1;
            ret_d    = seq_next_s;
            pc_sel_s = PC_VECTOR;
            itaken_d = 1'b1;
            addr_d   = INTERRUPT_VECTOR;
          end else begin
            pc_sel_s = should_branch ? PC_TARGET : PC_INC;
            addr_d   = seq_next_s;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
    // a pulse coinciding with a take re-arms the request
    pending_d = (pending_q && !take_s) || interruption;
    req_d     = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
  end

  // state and output registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      instr_q   <= INSTRUCTION_WIDTH'(NOP_INSTRUCTION);
      valid_q   <= 1'b0;
      ret_q     <= {DATA_WIDTH{1'b0}};
      pending_q <= 1'b0;
      itaken_q  <= 1'b0;
      addr_q    <= BOOT_ADDRESS;
      req_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      ret_q     <= ret_d;
      pending_q <= pending_d;
      itaken_q  <= itaken_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
    end
  end

  assign mem.mem_request   = req_q && reset;
  assign mem.mem_address   = addr_q;
  assign Instruction       = instr_q;
  assign instruction_valid = valid_q;
  assign pc                = pc_s;
  assign return_address    = ret_q;
  assign interrupt_taken   = itaken_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed and randomized checks of instruction_fetch against a
// transaction-level model of the program flow and a variable-latency memory.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        should_branch;
  logic [31:0] branch_target;
  logic        interruption;
  logic        is_os;
  logic [15:0] Instruction;
  logic        instruction_valid;
  logic [31:0] pc;
  logic [31:0] return_address;
  logic        interrupt_taken;

  int tests = 0;
  int fails = 0;

  instruction_fetch_if #(.DATA_WIDTH(32), .INSTRUCTION_WIDTH(16)) mif ();

  instruction_fetch dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .should_branch     (should_branch),
    .branch_target     (branch_target),
    .interruption      (interruption),
    .is_os             (is_os),
    .mem               (mif),
    .Instruction       (Instruction),
    .instruction_valid (instruction_valid),
    .pc                (pc),
    .return_address    (return_address),
    .interrupt_taken   (interrupt_taken)
  );

  always #5 clock = ~clock;

  // memory model: contents are a hash of the address, ready after lat waits
  logic [15:0] seed16      = 16'h0;
  logic        fixed_mode  = 1'b1;
  logic        ready_r     = 1'b0;
  logic        force_ready = 1'b0;
  int          lat         = 0;
  int          cnt         = 0;

  function automatic logic [15:0] mem_fn(input logic [31:0] a);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = a[15:0];
    hi = a[31:16];
    return (lo * 16'h9E37) ^ hi ^ seed16;
  endfunction

  assign mif.mem_ready = ready_r | force_ready;
  assign mif.mem_data  = fixed_mode ? 16'h1234 : mem_fn(mif.mem_address);

  always @(negedge clock) begin
    if (ready_r) cnt = 0;
    if (mif.mem_request) begin
      ready_r = (cnt >= lat);
      if (!ready_r) cnt = cnt + 1;
    end else begin
      ready_r = 1'b0;
      cnt     = 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!instruction_valid && n < max) begin
      tick();
      n++;
    end
    chk("wait_valid", 32'(instruction_valid), 32'd1);
  endtask

  task automatic consume(input logic br, input logic [31:0] tgt);
    enable        = 1'b1;
    should_branch = br;
    branch_target = tgt;
    tick();
    enable        = 1'b0;
    should_branch = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] exp_pc;
    logic [31:0] nxt;
    logic [31:0] tgt;
    logic        br;
    logic        irq;
    int          stalls;

    reset = 1'b0; enable = 1'b0; should_branch = 1'b0; branch_target = 32'h0;
    interruption = 1'b0; is_os = 1'b0;
    seed16 = 16'($urandom);

    // reset state
    tick(); tick(); tick();
    chk("rst_req",    32'(mif.mem_request),    32'd0);
    chk("rst_pc",     pc,                      32'h0);
    chk("rst_valid",  32'(instruction_valid),  32'd0);
    chk("rst_instr",  32'(Instruction),        32'h0);
    chk("rst_ret",    return_address,          32'h0);
    chk("rst_itaken", 32'(interrupt_taken),    32'd0);

    // zero-wait sequential fetch
    reset = 1'b1;
    tick();
    chk("first_req",  32'(mif.mem_request), 32'd1);
    chk("first_addr", mif.mem_address,      32'h0);
    tick();
    chk("first_valid", 32'(instruction_valid), 32'd1);
    chk("first_instr", 32'(Instruction),       32'h1234);
    chk("first_pc",    pc,                     32'h0);
    for (int i = 1; i <= 2; i++) begin
      consume(1'b0, 32'h0);
      chk("seq_addr", mif.mem_address, 32'(i));
      wait_valid(20, n);
      chk("seq_latency", 32'(n), 32'd1);
      chk("seq_pc",      pc,     32'(i));
    end

    // stall in HOLD
    fixed_mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_instr", 32'(Instruction),       32'h1234);
      chk("stall_pc",    pc,                     32'h2);
      chk("stall_valid", 32'(instruction_valid), 32'd1);
      chk("stall_req",   32'(mif.mem_request),   32'd0);
    end
    consume(1'b0, 32'h0);
    chk("stall_next_addr", mif.mem_address, 32'h3);
    wait_valid(20, n);
    chk("mem_instr", 32'(Instruction), 32'(mem_fn(32'h3)));

    // branch, with ignored branch while stalled
    consume(1'b1, 32'h5);
    wait_valid(20, n);
    should_branch = 1'b1; branch_target = 32'h77;
    tick(); tick();
    chk("br_ignored_pc",    pc,                     32'h5);
    chk("br_ignored_valid", 32'(instruction_valid), 32'd1);
    consume(1'b1, 32'h40);
    chk("br_addr", mif.mem_address, 32'h40);
    wait_valid(20, n);
    chk("br_pc",    pc,                32'h40);
    chk("br_instr", 32'(Instruction),  32'(mem_fn(32'h40)));

    // interrupt taken at the HOLD boundary
    consume(1'b1, 32'h7);
    wait_valid(20, n);
    chk("irq_hold_pc0", pc, 32'h7);
    interruption = 1'b1; tick(); interruption = 1'b0;
    consume(1'b0, 32'h0);
    chk("irq_hold_taken", 32'(interrupt_taken), 32'd1);
    chk("irq_hold_ret",   return_address,       32'h8);
    chk("irq_hold_addr",  mif.mem_address,      32'h100);
    tick();
    chk("irq_hold_pulse", 32'(interrupt_taken), 32'd0);
    wait_valid(20, n);

    // interrupt during a 3-cycle memory wait -> drain then vector fetch
    lat = 3;
    consume(1'b1, 32'h9);
    interruption = 1'b1; tick(); interruption = 1'b0;
    chk("drain_pre_taken", 32'(interrupt_taken), 32'd0);
    tick();
    chk("drain_taken", 32'(interrupt_taken), 32'd1);
    chk("drain_ret",   return_address,       32'h9);
    chk("drain_pc",    pc,                   32'h100);
    chk("drain_addr",  mif.mem_address,      32'h9);
    tick();
    chk("drain_addr_hold", mif.mem_address,      32'h9);
    chk("drain_req",       32'(mif.mem_request), 32'd1);
    chk("drain_valid",     32'(instruction_valid), 32'd0);
    tick();
    chk("drain_vec_addr",  mif.mem_address,        32'h100);
    chk("drain_discarded", 32'(instruction_valid), 32'd0);
    lat = 0;
    wait_valid(20, n);
    chk("drain_vec_pc",    pc,               32'h100);
    chk("drain_vec_instr", 32'(Instruction), 32'(mem_fn(32'h100)));

    // masking by is_os until the next boundary with is_os low
    is_os = 1'b1;
    interruption = 1'b1; tick(); interruption = 1'b0;
    consume(1'b0, 32'h0);
    chk("mask_taken", 32'(interrupt_taken), 32'd0);
    chk("mask_addr",  mif.mem_address,      32'h101);
    wait_valid(20, n);
    chk("mask_pc", pc, 32'h101);
    is_os = 1'b0;
    consume(1'b0, 32'h0);
    chk("unmask_taken", 32'(interrupt_taken), 32'd1);
    chk("unmask_ret",   return_address,       32'h102);
    chk("unmask_addr",  mif.mem_address,      32'h100);
    wait_valid(20, n);

    // pc wrap
    consume(1'b1, 32'hFFFF_FFFF);
    wait_valid(20, n);
    chk("wrap_pc0", pc, 32'hFFFF_FFFF);
    consume(1'b0, 32'h0);
    chk("wrap_pc",   pc,              32'h0);
    chk("wrap_addr", mif.mem_address, 32'h0);
    wait_valid(20, n);

    // reset while draining; late ready ignored
    lat = 3;
    consume(1'b0, 32'h0);
    interruption = 1'b1; tick(); interruption = 1'b0;
    tick();
    chk("rd_pc_vec", pc, 32'h100);
    reset = 1'b0; force_ready = 1'b1;
    tick();
    chk("rd_pc",     pc,                     32'h0);
    chk("rd_req",    32'(mif.mem_request),   32'd0);
    chk("rd_itaken", 32'(interrupt_taken),   32'd0);
    tick();
    chk("rd_valid", 32'(instruction_valid), 32'd0);
    reset = 1'b1;
    tick();
    chk("rd_idle_valid", 32'(instruction_valid), 32'd0);
    chk("rd_addr",       mif.mem_address,        32'h0);
    force_ready = 1'b0; lat = 0;
    wait_valid(20, n);
    chk("rd_refetch_pc",    pc,               32'h0);
    chk("rd_refetch_instr", 32'(Instruction), 32'(mem_fn(32'h0)));

    // randomized program flow against the transaction model
    exp_pc = 32'h0;
    for (int i = 0; i < 150; i++) begin
      wait_valid(50, n);
      chk("rnd_pc",    pc,               exp_pc);
      chk("rnd_instr", 32'(Instruction), 32'(mem_fn(exp_pc)));
      irq    = ($urandom_range(0, 7) == 0);
      stalls = int'($urandom_range(0, 2));
      if (irq) begin
        interruption = 1'b1; tick(); interruption = 1'b0;
      end
      for (int s = 0; s < stalls; s++) begin
        should_branch = 1'($urandom_range(0, 1));
        branch_target = $urandom;
        tick();
        chk("rnd_stall_pc", pc, exp_pc);
      end
      lat = int'($urandom_range(0, 3));
      br  = 1'($urandom_range(0, 1));
      tgt = $urandom;
      nxt = br ? tgt : exp_pc + 32'd1;
      consume(br, tgt);
      chk("rnd_itaken", 32'(interrupt_taken), 32'(irq));
      if (irq) begin
        chk("rnd_ret", return_address, nxt);
        exp_pc = 32'h100;
      end else begin
        exp_pc = nxt;
      end
      chk("rnd_addr", mif.mem_address, exp_pc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
